// File: rtl/imm_ext_ctrl_if.sv
// Decode-to-execute immediate handshake bundle.
// slave: the extender block; master: the decode/execute side driving it.
interface imm_ext_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [1:0]  out_mode;

  modport slave (
    input  in_valid,
    input  instruction,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_imm,
    output out_mode
  );

  modport master (
    output in_valid,
    output instruction,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_imm,
    input  out_mode
  );
endinterface

// File: rtl/imm_ext_ctrl.sv
// MIPS immediate extender with a 2-entry in-order skid buffer.
// Ports: clk, rst_n (async, active low), bus (imm_ext_ctrl_if.slave),
// stall_cnt (16b stall counter, only when IMM_STATS_EN is defined).
module imm_ext_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  imm_ext_ctrl_if.slave bus
`ifdef IMM_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SIGN  = 2'd0;
  localparam logic [1:0] MODE_ZERO  = 2'd1;
  localparam logic [1:0] MODE_LUI   = 2'd2;
  localparam logic [1:0] MODE_SHAMT = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] head_imm_q, head_imm_d;
  logic [1:0]  head_mode_q, head_mode_d;
  logic [31:0] tail_imm_q, tail_imm_d;
  logic [1:0]  tail_mode_q, tail_mode_d;

  logic        accept, pop;
  logic [5:0]  op;
  logic        is_zero, is_lui, is_shamt;
  logic [31:0] dec_imm;
  logic [1:0]  dec_mode;
  logic        unused_instr;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  // Immediate decode
  assign op       = bus.instruction[31:26];
  assign is_zero  = (op == 6'h0C) || (op == 6'h0D)
                 || (op == 6'h0E);
  assign is_lui   = (op == 6'h0F);
  assign is_shamt = (op == 6'h00);
  assign unused_instr = ^bus.instruction[25:16];

  always_comb begin
    dec_mode = MODE_SIGN;
    dec_imm  = {{16{bus.instruction[15]}},
                bus.instruction[15:0]};
    unique case (1'b1)
      is_zero: begin
        dec_mode = MODE_ZERO;
        dec_imm  = {16'h0000, bus.instruction[15:0]};
      end
      is_lui: begin
        dec_mode = MODE_LUI;
        dec_imm  = {bus.instruction[15:0], 16'h0000};
      end
      is_shamt: begin
        dec_mode = MODE_SHAMT;
        dec_imm  = {27'b0, bus.instruction[10:6]};
      end
      default: begin
        dec_mode = MODE_SIGN;
        dec_imm  = {{16{bus.instruction[15]}},
                    bus.instruction[15:0]};
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // FSM next state; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept && !pop)      state_d = FULL;
          else if (pop && !accept) state_d = EMPTY;
        end
        FULL: if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // FSM outputs from registered state only
  always_comb begin
    bus.in_ready  = (state_q != FULL);
    bus.out_valid = (state_q != EMPTY);
  end

  // Entry storage: head is always the oldest entry
  always_comb begin
    head_imm_d  = head_imm_q;
    head_mode_d = head_mode_q;
    tail_imm_d  = tail_imm_q;
    tail_mode_d = tail_mode_q;
    if (!bus.flush) begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_imm_d  = dec_imm;
            head_mode_d = dec_mode;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_imm_d  = dec_imm;
            head_mode_d = dec_mode;
          end else if (accept) begin
            tail_imm_d  = dec_imm;
            tail_mode_d = dec_mode;
          end
        end
        FULL: begin
          if (pop) begin
            head_imm_d  = tail_imm_q;
            head_mode_d = tail_mode_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_imm_q  <= 32'h0;
      head_mode_q <= MODE_SIGN;
      tail_imm_q  <= 32'h0;
      tail_mode_q <= MODE_SIGN;
    end else begin
      head_imm_q  <= head_imm_d;
      head_mode_q <= head_mode_d;
      tail_imm_q  <= tail_imm_d;
      tail_mode_q <= tail_mode_d;
    end
  end

  assign bus.out_imm  = head_imm_q;
  assign bus.out_mode = head_mode_q;

`ifdef IMM_STATS_EN
  // Saturating count of cycles the head waits on execute
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.out_valid && !bus.out_ready
        && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 16'h0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Self-checking bench for imm_ext_ctrl.
// Scenario tasks plus a negedge scoreboard of expected head entries.
module tb_imm_ext_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_ext_ctrl_if bus ();

`ifdef IMM_STATS_EN
  logic [15:0] stall_cnt;
`endif

  imm_ext_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IMM_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    case (w[31:26])
      6'h0C, 6'h0D, 6'h0E: begin
        e.imm = {16'h0000, w[15:0]}; e.mode = 2'd1;
      end
      6'h0F: begin
        e.imm = {w[15:0], 16'h0000}; e.mode = 2'd2;
      end
      6'h00: begin
        e.imm = {27'b0, w[10:6]}; e.mode = 2'd3;
      end
      default: begin
        e.imm = {{16{w[15]}}, w[15:0]}; e.mode = 2'd0;
      end
    endcase
    return e;
  endfunction

  // Scoreboard: inputs are stable at negedge, so the
  // events seen here are what the next posedge commits.
  always @(negedge clk) begin
    exp_t h;
    if (!rst_n || bus.flush) begin
      sb.delete();
    end else begin
      checks++;
      if (bus.out_valid !== (sb.size() != 0)
          || bus.in_ready !== (sb.size() < 2)) begin
        failures++;
        $display("FAIL sb_occupancy: out_valid=%b in_ready=%b expected entries=%0d",
                 bus.out_valid, bus.in_ready, sb.size());
      end
      if (bus.out_valid && sb.size() != 0) begin
        h = sb[0];
        checks++;
        if (bus.out_imm !== h.imm || bus.out_mode !== h.mode) begin
          failures++;
          $display("FAIL sb_head: got imm=%h mode=%0d expected imm=%h mode=%0d",
                   bus.out_imm, bus.out_mode, h.imm, h.mode);
        end
        if (bus.out_ready) void'(sb.pop_front());
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.instruction));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.instruction = 32'h0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
        || bus.out_imm !== 32'h0 || bus.out_mode !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%b r=%b imm=%h mode=%0d expected v=0 r=1 imm=0 mode=0",
               bus.out_valid, bus.in_ready, bus.out_imm, bus.out_mode);
    end
`ifdef IMM_STATS_EN
    checks++;
    if (stall_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_stall: got %h expected 0000", stall_cnt);
    end
`endif
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] w [4];
    logic [31:0] ei [4];
    logic [1:0]  em [4];
    w[0] = 32'h2008FFFC; ei[0] = 32'hFFFFFFFC; em[0] = 2'd0;
    w[1] = 32'h3008FFFC; ei[1] = 32'h0000FFFC; em[1] = 2'd1;
    w[2] = 32'h3C081234; ei[2] = 32'h12340000; em[2] = 2'd2;
    w[3] = 32'h00084080; ei[3] = 32'h00000002; em[3] = 2'd3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid    = 1'b1;
      bus.instruction = w[i];
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_imm !== ei[i]
          || bus.out_mode !== em[i]) begin
        failures++;
        $display("FAIL decode_%0d: got v=%b imm=%h mode=%0d expected v=1 imm=%h mode=%0d",
                 i, bus.out_valid, bus.out_imm, bus.out_mode, ei[i], em[i]);
      end
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL decode_drain: got v=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h2008000A;
    step();
    bus.instruction = 32'h2008000B;
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1
        || bus.out_imm !== 32'h0000000A) begin
      failures++;
      $display("FAIL bp_full: got r=%b v=%b imm=%h expected r=0 v=1 imm=0000000A",
               bus.in_ready, bus.out_valid, bus.out_imm);
    end
    bus.instruction = 32'h2008000C;
    step();
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_imm !== 32'h0000000A) begin
      failures++;
      $display("FAIL bp_hold: got r=%b imm=%h expected r=0 imm=0000000A",
               bus.in_ready, bus.out_imm);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_imm !== 32'h0000000B || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_pop_a: got imm=%h r=%b expected imm=0000000B r=1",
               bus.out_imm, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_imm !== 32'h0000000C || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_pop_b: got imm=%h v=%b expected imm=0000000C v=1",
               bus.out_imm, bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got v=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_push_pop();
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h2008000A;
    step();
    bus.out_ready   = 1'b1;
    bus.instruction = 32'h2008000B;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_imm !== 32'h0000000B || bus.out_valid !== 1'b1
        || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_pop: got imm=%h v=%b r=%b expected imm=0000000B v=1 r=1",
               bus.out_imm, bus.out_valid, bus.in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL push_pop_drain: got v=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h2008000A;
    step();
    bus.instruction = 32'h2008000B;
    step();
    bus.instruction = 32'h00000000;
    step();
    bus.flush       = 1'b1;
    bus.out_ready   = 1'b1;
    bus.instruction = 32'h2008000D;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got v=%b r=%b expected v=0 r=1",
               bus.out_valid, bus.in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_nostore: got v=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h2008000A;
    step();
    bus.instruction = 32'h2008000B;
    step();
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
        || bus.out_imm !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: got v=%b r=%b imm=%h expected v=0 r=1 imm=0",
               bus.out_valid, bus.in_ready, bus.out_imm);
    end
    step();
    rst_n = 1'b1;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h3C08ABCD;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'hABCD0000) begin
      failures++;
      $display("FAIL post_reset_accept: got v=%b imm=%h expected v=1 imm=ABCD0000",
               bus.out_valid, bus.out_imm);
    end
    step();
  endtask

`ifdef IMM_STATS_EN
  task automatic test_stall_cnt();
    rst_n = 1'b0;
    idle_inputs();
    step();
    rst_n = 1'b1;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'h2008000A;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL stall_5: got %0d expected 5", stall_cnt);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    checks++;
    if (stall_cnt !== 16'd6 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_flush: got cnt=%0d v=%b expected cnt=6 v=0",
               stall_cnt, bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stall_reset: got %0d expected 0", stall_cnt);
    end
    step();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_push_pop();
    test_flush();
    test_async_reset();
`ifdef IMM_STATS_EN
    test_stall_cnt();
`endif
    idle_inputs();
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_ext_ctrl.md
IMM_EXT_CTRL -- requirements
Module: imm_ext_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase does: clk and rst_n.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  decode stage presents an instruction.
- in_ready  output  1  block can accept an instruction this cycle.
- instruction  input  32  raw MIPS instruction word.
- flush  input  1  synchronous pipeline flush (branch/exception).
- out_valid  output  1  out_imm/out_mode hold a valid entry.
- out_ready  input  1  execute stage consumes the head entry.
- out_imm  output  32  extended immediate of the head entry.
- out_mode  output  2  head entry mode: 0 sign, 1 zero, 2 lui, 3 shamt.
- stall_cnt  output  16  present only with IMM_STATS_EN.

Function
REQ-003 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-004 The mode SHALL be decoded from instruction[31:26]:
- 0x0C, 0x0D, 0x0E (andi/ori/xori) -> zero, giving {16'h0000, instr[15:0]}.
- 0x0F (lui) -> lui, giving {instr[15:0], 16'h0000}.
- 0x00 (R-type) -> shamt, giving {27'b0, instr[10:6]}.
- any other opcode -> sign, giving {{16{instr[15]}}, instr[15:0]}.
REQ-005 Storage SHALL be a 2-entry in-order skid buffer controlled by an FSM with states EMPTY, ONE and FULL.
REQ-006 in_ready SHALL equal (state != FULL), decoded combinationally from the registered state.
REQ-007 out_valid SHALL equal (state != EMPTY); out_imm and out_mode SHALL always show the oldest entry.
REQ-008 FSM transitions SHALL be:
- EMPTY: accept -> ONE.
- ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept and pop -> ONE, with the new entry at the head next cycle.
- FULL: pop -> ONE, with the second entry promoted to head.
REQ-009 Latency SHALL be 1 cycle: an entry accepted at edge N SHALL be visible at the outputs after edge N, if the buffer was EMPTY or held one entry being popped.
REQ-010 Entries SHALL leave in the order they were accepted; no entry SHALL be duplicated or dropped except by flush.
REQ-011 When flush is asserted, the next edge SHALL drive the state to EMPTY and discard all entries; any accept or pop in that same cycle SHALL be ignored, and flush SHALL win over every other event.
REQ-012 Registered outputs SHALL NOT glitch; out_imm and out_mode SHALL hold their values while out_valid && !out_ready.

Reset
REQ-013 While rst_n is low:
- state = EMPTY, out_valid = 0, out_imm = 32'h0, out_mode = 0, stall_cnt = 0.
- in_ready = 1.
REQ-014 Reset asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-015 After rst_n rises, the first accept SHALL be possible on the first clock edge.

Configuration
REQ-016 With macro IMM_STATS_EN defined:
- The stall_cnt port SHALL exist.
- stall_cnt SHALL increment each cycle in which out_valid && !out_ready, saturating at 16'hFFFF.
- flush SHALL NOT clear stall_cnt; only reset clears it.
REQ-017 With IMM_STATS_EN undefined, the stall_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-018 Mode decode: push 0x2008FFFC (addi), 0x3008FFFC (andi), 0x3C081234 (lui) and 0x00084080 (sll shamt 2) with out_ready=1 -> out_imm must be FFFFFFFC/0, 0000FFFC/1, 12340000/2 and 00000002/3, in order, each one cycle after its accept.
REQ-019 Backpressure: out_ready=0 while pushing A=0x2008000A, B=0x2008000B, C -> FULL after B, in_ready=0, C held; then out_ready=1 -> A, B, C emerge in order, none lost.
REQ-020 Simultaneous push/pop in ONE: head A, out_ready=1, push B -> state stays ONE, out_imm = 0000000B next cycle.
REQ-021 Flush: FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the pushed word is not stored.
REQ-022 Async reset: rst_n dropped mid-cycle while FULL -> out_valid=0 immediately and in_ready=1; with IMM_STATS_EN, 5 stall cycles -> stall_cnt=5, then reset -> stall_cnt=0.
